// File: rtl/nco_voice.sv
// Single-voice sine NCO: free-running sample/bit-clock divider, 32-bit phase accumulator,
// quarter-wave sine ROM with linear interpolation between adjacent table entries.
module nco_voice #(
   parameter int SAMPLE_DIV = 512,
   parameter int BIT_DIV    = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                 master_clk,
   input  logic                 rst,
   input  logic                 nco_mute,
   input  logic [ACC_WIDTH-1:0] accumulator_increment_value,
   output logic                 sample_clk_en,
   output logic                 bit_clk_en,
   output logic [OUT_WIDTH-1:0] sample_output,
   output logic [ACC_WIDTH-1:0] accumulator_value,
   output logic [OUT_WIDTH-1:0] sample_li_offset
);

   localparam int CW = $clog2(SAMPLE_DIV);
   localparam int BW = $clog2(BIT_DIV);

   logic [CW-1:0]               r_cnt;
   logic [ACC_WIDTH-1:0]        r_acc;
   logic [OUT_WIDTH-1:0]        r_sample;
   logic [OUT_WIDTH-1:0]        r_offset;

   logic [7:0]                  w_idx;
   logic [7:0]                  w_idx_next;
   logic [7:0]                  w_frac;
   logic signed [OUT_WIDTH-1:0] w_s0;
   logic signed [OUT_WIDTH-1:0] w_s1;
   logic signed [OUT_WIDTH:0]   w_diff;
   logic signed [OUT_WIDTH+9:0] w_prod;
   logic [OUT_WIDTH-1:0]        w_off;
   logic [OUT_WIDTH-1:0]        w_y;

   // First quadrant of round(32767*sin(2*pi*a/256)), a = 0..64.
   function automatic logic [15:0] quarter_sine(input logic [6:0] a);
      logic [15:0] v;
      case (a)
         7'd0:  v = 16'd0;     7'd1:  v = 16'd804;   7'd2:  v = 16'd1608;  7'd3:  v = 16'd2410;
         7'd4:  v = 16'd3212;  7'd5:  v = 16'd4011;  7'd6:  v = 16'd4808;  7'd7:  v = 16'd5602;
         7'd8:  v = 16'd6393;  7'd9:  v = 16'd7179;  7'd10: v = 16'd7962;  7'd11: v = 16'd8739;
         7'd12: v = 16'd9512;  7'd13: v = 16'd10278; 7'd14: v = 16'd11039; 7'd15: v = 16'd11793;
         7'd16: v = 16'd12539; 7'd17: v = 16'd13279; 7'd18: v = 16'd14010; 7'd19: v = 16'd14732;
         7'd20: v = 16'd15446; 7'd21: v = 16'd16151; 7'd22: v = 16'd16846; 7'd23: v = 16'd17530;
         7'd24: v = 16'd18204; 7'd25: v = 16'd18868; 7'd26: v = 16'd19519; 7'd27: v = 16'd20159;
         7'd28: v = 16'd20787; 7'd29: v = 16'd21403; 7'd30: v = 16'd22005; 7'd31: v = 16'd22594;
         7'd32: v = 16'd23170; 7'd33: v = 16'd23731; 7'd34: v = 16'd24279; 7'd35: v = 16'd24811;
         7'd36: v = 16'd25329; 7'd37: v = 16'd25832; 7'd38: v = 16'd26319; 7'd39: v = 16'd26790;
         7'd40: v = 16'd27245; 7'd41: v = 16'd27683; 7'd42: v = 16'd28105; 7'd43: v = 16'd28510;
         7'd44: v = 16'd28898; 7'd45: v = 16'd29268; 7'd46: v = 16'd29621; 7'd47: v = 16'd29956;
         7'd48: v = 16'd30273; 7'd49: v = 16'd30571; 7'd50: v = 16'd30852; 7'd51: v = 16'd31113;
         7'd52: v = 16'd31356; 7'd53: v = 16'd31580; 7'd54: v = 16'd31785; 7'd55: v = 16'd31971;
         7'd56: v = 16'd32137; 7'd57: v = 16'd32285; 7'd58: v = 16'd32412; 7'd59: v = 16'd32521;
         7'd60: v = 16'd32609; 7'd61: v = 16'd32678; 7'd62: v = 16'd32728; 7'd63: v = 16'd32757;
         7'd64: v = 16'd32767;
         default: v = 16'd0;
      endcase
      return v;
   endfunction

   // Full 256-entry table by mirroring within each half wave and negating the second half.
   function automatic logic [15:0] sine_rom(input logic [7:0] i);
      logic [7:0]  j;
      logic [6:0]  a;
      logic [15:0] m;
      j = {1'b0, i[6:0]};
      a = (j <= 8'd64) ? j[6:0] : 7'(8'd128 - j);
      m = quarter_sine(a);
      return i[7] ? 16'(-m) : m;
   endfunction

   assign w_idx      = r_acc[ACC_WIDTH-1 -: 8];
   assign w_frac     = r_acc[ACC_WIDTH-9 -: 8];
   assign w_idx_next = w_idx + 8'd1;
   assign w_s0       = OUT_WIDTH'(sine_rom(w_idx));
   assign w_s1       = OUT_WIDTH'(sine_rom(w_idx_next));
   assign w_diff     = {w_s1[OUT_WIDTH-1], w_s1} - {w_s0[OUT_WIDTH-1], w_s0};
   assign w_prod     = (OUT_WIDTH+10)'(w_diff) * (OUT_WIDTH+10)'($signed({1'b0, w_frac}));
   assign w_off      = OUT_WIDTH'(w_prod >>> 8);
   assign w_y        = w_s0 + w_off;

   // Divider assumes SAMPLE_DIV and BIT_DIV are powers of two, so every sample enable is also a bit enable.
   assign sample_clk_en = (r_cnt == CW'(SAMPLE_DIV - 1));
   assign bit_clk_en    = (r_cnt[BW-1:0] == {BW{1'b1}});

   always_ff @(posedge master_clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_sample <= '0;
         r_offset <= '0;
      end else begin
         if (sample_clk_en) begin
            r_cnt    <= '0;
            r_acc    <= r_acc + accumulator_increment_value;
            r_offset <= w_off;
            r_sample <= nco_mute ? '0 : w_y;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign sample_output     = r_sample;
   assign accumulator_value = r_acc;
   assign sample_li_offset  = r_offset;

endmodule

// File: tb/tb_nco_voice.sv
// Bench for nco_voice: divider timing, reset, fixed-step sine sequences, mute, step changes
// and randomized increments checked against a real-valued sine table and phase model.
module tb_nco_voice;

   logic        master_clk = 1'b0;
   logic        rst = 1'b1;
   logic        nco_mute = 1'b0;
   logic [31:0] inc = 32'd0;
   logic        sample_clk_en;
   logic        bit_clk_en;
   logic [15:0] sample_output;
   logic [31:0] accumulator_value;
   logic [15:0] sample_li_offset;

   int          n_chk = 0;
   int          n_fail = 0;
   int          tab[256];
   logic [31:0] exp_acc = 32'd0;
   logic [15:0] exp_y = 16'd0;
   logic [15:0] exp_off = 16'd0;

   nco_voice dut (
      .master_clk                  (master_clk),
      .rst                         (rst),
      .nco_mute                    (nco_mute),
      .accumulator_increment_value (inc),
      .sample_clk_en               (sample_clk_en),
      .bit_clk_en                  (bit_clk_en),
      .sample_output               (sample_output),
      .accumulator_value           (accumulator_value),
      .sample_li_offset            (sample_li_offset)
   );

   always #5 master_clk = ~master_clk;

   // Reference sample at a given phase: table lookup plus linear interpolation on plain ints.
   function automatic void ref_sample(input logic [31:0] ph, input logic mute,
                                      output logic [15:0] y, output logic [15:0] off);
      int idx, frac, s0, s1, o;
      idx  = int'(ph[31:24]);
      frac = int'(ph[23:16]);
      s0   = tab[idx];
      s1   = tab[(idx + 1) % 256];
      o    = ((s1 - s0) * frac) >>> 8;
      off  = 16'(o);
      y    = mute ? 16'd0 : 16'(s0 + o);
   endfunction

   task automatic do_reset();
      @(negedge master_clk);
      rst = 1'b1;
      repeat (2) @(negedge master_clk);
      rst = 1'b0;
      exp_acc = 32'd0;
      exp_y   = 16'd0;
      exp_off = 16'd0;
   endtask

   // Waits for the next sample enable, optionally changing inputs part-way, and checks that
   // the outputs hold their previous values on every cycle in between.
   task automatic step(input int chg_at, input logic [31:0] new_inc, input logic new_mute);
      bit          held;
      bit          got;
      logic [15:0] bad_y;
      logic [31:0] bad_acc;
      held = 1'b1;
      got  = 1'b0;
      bad_y = 16'd0;
      bad_acc = 32'd0;
      for (int c = 0; c < 600; c++) begin
         @(negedge master_clk);
         if (c == chg_at) begin
            inc = new_inc;
            nco_mute = new_mute;
         end
         if (sample_clk_en) begin
            got = 1'b1;
            break;
         end
         if (held && (sample_output !== exp_y || accumulator_value !== exp_acc ||
                      sample_li_offset !== exp_off)) begin
            held = 1'b0;
            bad_y = sample_output;
            bad_acc = accumulator_value;
         end
      end
      n_chk++;
      if (!held) begin
         n_fail++;
         $display("FAIL hold: between enables y=%0d acc=%h, expected y=%0d acc=%h",
                  $signed(bad_y), bad_acc, $signed(exp_y), exp_acc);
      end
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL timeout: no sample_clk_en within 600 cycles, expected one within 512");
      end
      if (got) begin
         @(posedge master_clk);
         #1;
      end
   endtask

   task automatic test_reset();
      int first_bit, first_smp, nbits, gap;
      bit coinc;
      do_reset();
      inc = 32'h4000_0000;
      repeat (1100) @(posedge master_clk);
      #3;
      rst = 1'b1;
      #1;
      n_chk++;
      if (sample_output !== 16'd0 || accumulator_value !== 32'd0 || sample_li_offset !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_clear: y=%0d acc=%h off=%0d, expected all 0",
                  $signed(sample_output), accumulator_value, $signed(sample_li_offset));
      end
      n_chk++;
      if (sample_clk_en !== 1'b0 || bit_clk_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_en: sample_en=%b bit_en=%b, expected 0 0", sample_clk_en, bit_clk_en);
      end
      inc = 32'd0;
      repeat (3) @(negedge master_clk);
      rst = 1'b0;
      first_bit = 0;
      first_smp = 0;
      for (int c = 1; c <= 600; c++) begin
         @(posedge master_clk);
         #1;
         if (bit_clk_en && first_bit == 0) first_bit = c;
         if (sample_clk_en) begin
            first_smp = c;
            break;
         end
      end
      n_chk++;
      if (first_bit != 7) begin
         n_fail++;
         $display("FAIL first_bit_en: after %0d edges, expected 7", first_bit);
      end
      n_chk++;
      if (first_smp != 511) begin
         n_fail++;
         $display("FAIL first_sample_en: after %0d edges, expected 511", first_smp);
      end
      nbits = 0;
      gap = 0;
      coinc = 1'b1;
      for (int c = 1; c <= 600; c++) begin
         @(posedge master_clk);
         #1;
         if (bit_clk_en) nbits++;
         if (sample_clk_en && !bit_clk_en) coinc = 1'b0;
         if (sample_clk_en) begin
            gap = c;
            break;
         end
      end
      n_chk++;
      if (gap != 512) begin
         n_fail++;
         $display("FAIL sample_period: %0d cycles, expected 512", gap);
      end
      n_chk++;
      if (nbits != 64) begin
         n_fail++;
         $display("FAIL bits_per_sample: %0d, expected 64", nbits);
      end
      n_chk++;
      if (!coinc) begin
         n_fail++;
         $display("FAIL en_coincide: sample_clk_en without bit_clk_en, expected coincident");
      end
   endtask

   task automatic test_slow_ramp();
      int known[5] = '{0, 402, 804, 1206, 1608};
      logic [31:0] ph;
      do_reset();
      inc = 32'h0080_0000;
      for (int k = 0; k < 10; k++) begin
         step(-1, inc, nco_mute);
         ph = 32'(k) * inc;
         ref_sample(ph, 1'b0, exp_y, exp_off);
         exp_acc = ph + inc;
         n_chk++;
         if (sample_output !== exp_y || sample_li_offset !== exp_off || accumulator_value !== exp_acc) begin
            n_fail++;
            $display("FAIL ramp[%0d]: y=%0d off=%0d acc=%h, expected y=%0d off=%0d acc=%h", k,
                     $signed(sample_output), $signed(sample_li_offset), accumulator_value,
                     $signed(exp_y), $signed(exp_off), exp_acc);
         end
         if (k < 5) begin
            n_chk++;
            if (sample_output !== 16'(known[k])) begin
               n_fail++;
               $display("FAIL ramp_known[%0d]: y=%0d, expected %0d", k, $signed(sample_output), known[k]);
            end
         end
      end
   endtask

   task automatic test_peak();
      do_reset();
      inc = 32'h0800_0000;
      for (int k = 0; k <= 8; k++) begin
         step(-1, inc, nco_mute);
         ref_sample(32'(k) * inc, 1'b0, exp_y, exp_off);
         exp_acc = 32'(k + 1) * inc;
      end
      n_chk++;
      if (sample_output !== 16'd32767) begin
         n_fail++;
         $display("FAIL peak: y=%0d, expected 32767", $signed(sample_output));
      end
   endtask

   task automatic test_quadrature();
      int q[4] = '{0, 32767, 0, -32767};
      do_reset();
      inc = 32'h4000_0000;
      for (int k = 0; k < 8; k++) begin
         step(-1, inc, nco_mute);
         exp_y   = 16'(q[k % 4]);
         exp_off = 16'd0;
         exp_acc = 32'(k + 1) * inc;
         n_chk++;
         if (sample_output !== exp_y || sample_li_offset !== 16'd0 || accumulator_value !== exp_acc) begin
            n_fail++;
            $display("FAIL quad[%0d]: y=%0d off=%0d acc=%h, expected y=%0d off=0 acc=%h", k,
                     $signed(sample_output), $signed(sample_li_offset), accumulator_value,
                     $signed(exp_y), exp_acc);
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] wacc[4] = '{32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      int          wy[4]   = '{0, -32767, 0, 32767};
      do_reset();
      inc = 32'hC000_0000;
      for (int k = 0; k < 4; k++) begin
         step(-1, inc, nco_mute);
         exp_y   = 16'(wy[k]);
         exp_off = 16'd0;
         exp_acc = wacc[k];
         n_chk++;
         if (sample_output !== exp_y || accumulator_value !== exp_acc) begin
            n_fail++;
            $display("FAIL wrap[%0d]: y=%0d acc=%h, expected y=%0d acc=%h", k,
                     $signed(sample_output), accumulator_value, $signed(exp_y), exp_acc);
         end
      end
   endtask

   task automatic test_mute();
      int q[4] = '{0, 32767, 0, -32767};
      do_reset();
      inc = 32'h4000_0000;
      nco_mute = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step((k == 4) ? 100 : -1, inc, 1'b0);
         exp_y   = (k < 4) ? 16'd0 : 16'(q[k % 4]);
         exp_off = 16'd0;
         exp_acc = 32'(k + 1) * inc;
         n_chk++;
         if (sample_output !== exp_y || accumulator_value !== exp_acc) begin
            n_fail++;
            $display("FAIL mute[%0d]: y=%0d acc=%h, expected y=%0d acc=%h", k,
                     $signed(sample_output), accumulator_value, $signed(exp_y), exp_acc);
         end
      end
   endtask

   task automatic test_increment_change();
      logic [31:0] ph;
      do_reset();
      inc = 32'h0100_0000;
      ph = 32'd0;
      for (int k = 0; k < 8; k++) begin
         if (k == 3)      step(200, 32'h0300_0000, 1'b0);
         else if (k == 5) step(510, 32'h0040_0000, 1'b0);
         else             step(-1, inc, nco_mute);
         ref_sample(ph, nco_mute, exp_y, exp_off);
         ph = ph + inc;
         exp_acc = ph;
         n_chk++;
         if (sample_output !== exp_y || sample_li_offset !== exp_off || accumulator_value !== exp_acc) begin
            n_fail++;
            $display("FAIL inc_change[%0d]: y=%0d off=%0d acc=%h, expected y=%0d off=%0d acc=%h", k,
                     $signed(sample_output), $signed(sample_li_offset), accumulator_value,
                     $signed(exp_y), $signed(exp_off), exp_acc);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] ph;
      logic [31:0] ni;
      logic        nm;
      do_reset();
      nco_mute = 1'b0;
      inc = $urandom;
      ph = 32'd0;
      for (int k = 0; k < 30; k++) begin
         ni = $urandom;
         nm = ($urandom_range(0, 3) == 0);
         step(int'($urandom_range(0, 510)), ni, nm);
         ref_sample(ph, nco_mute, exp_y, exp_off);
         ph = ph + inc;
         exp_acc = ph;
         n_chk++;
         if (sample_output !== exp_y || sample_li_offset !== exp_off || accumulator_value !== exp_acc) begin
            n_fail++;
            $display("FAIL random[%0d]: y=%0d off=%0d acc=%h, expected y=%0d off=%0d acc=%h", k,
                     $signed(sample_output), $signed(sample_li_offset), accumulator_value,
                     $signed(exp_y), $signed(exp_off), exp_acc);
         end
      end
   endtask

   initial begin
      real r;
      for (int i = 0; i < 256; i++) begin
         r = 32767.0 * $sin(2.0 * 3.141592653589793 * real'(i) / 256.0);
         tab[i] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
      end
      test_reset();
      test_slow_ramp();
      test_peak();
      test_quadrature();
      test_wrap();
      test_mute();
      test_increment_change();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/nco_voice.md
# nco_voice

Single-voice audio oscillator core for the synth datapath. A free-running divider turns the 24.576 MHz master clock into a 48 kHz sample enable and a 3.072 MHz bit-clock enable. A 32-bit phase-accumulator NCO advances once per sample and produces a linearly interpolated 16-bit signed sine sample. Downstream it feeds the I2S serializer, which uses the same enables.

## Interface
Parameters:
- SAMPLE_DIV, 512: master clocks per sample enable (48 kHz at 24.576 MHz).
- BIT_DIV, 8: master clocks per bit-clock enable (64 bits per sample).
- ACC_WIDTH, 32: phase accumulator width.
- OUT_WIDTH, 16: sample width, two's complement.

Ports:
- master_clk  in  1  the single system clock, 24.576 MHz.
- rst  in  1  reset, asynchronous, active-high.
- nco_mute  in  1  forces the sample output to 0.
- accumulator_increment_value  in  32  phase step per sample; output frequency = inc × 48000 / 2^32 Hz.
- sample_clk_en  out  1  one-cycle pulse, 1 of every SAMPLE_DIV cycles.
- bit_clk_en  out  1  one-cycle pulse, 1 of every BIT_DIV cycles.
- sample_output  out  16  registered signed sine sample.
- accumulator_value  out  32  current phase accumulator (debug).
- sample_li_offset  out  16  signed interpolation term of the latest computed sample (debug).

## Operation
Divider:
- 9-bit counter cnt, +1 every master_clk cycle, wraps 511→0.
- sample_clk_en = (cnt == 511).
- bit_clk_en = (cnt[2:0] == 7).
- Both enables are decoded from the registered counter, so they are glitch-free.

Phase and index:
- idx = acc[31:24].
- frac = acc[23:16] (unsigned).
- acc[15:0] is phase precision only.

ROM:
- 256 entries, 16-bit signed.
- T[i] = round(32767 × sin(2πi/256)).
- Examples: T[0]=0, T[1]=804, T[64]=32767, T[128]=0, T[192]=-32767.
- Implement as a case ROM or a synthesizable constant array.

Interpolation:
- s0 = T[idx], s1 = T[(idx+1) mod 256]. Index 255 interpolates toward T[0].
- off = ((s1 − s0) × frac) >>> 8, using a 17-bit signed difference, a 26-bit product and an arithmetic shift, truncated to 16 bits.
- y = s0 + off. This never overflows because y lies between s0 and s1.

On each master_clk edge with sample_clk_en = 1:
- acc ← acc + accumulator_increment_value, modulo 2^32.
- sample_li_offset ← off, computed from the pre-update acc.
- sample_output ← nco_mute ? 0 : y, computed from the pre-update acc.

Other rules:
- The sample emitted at enable k therefore corresponds to phase k × inc (k = 0 is the first enable after reset).
- Mute does not stop the accumulator. Phase keeps advancing while muted, and unmuting resumes at the advanced phase.
- nco_mute and the increment are sampled only on enable cycles. Changing them between enables has no effect until the next enable, and causes no phase reset.

## Timing
- Reset (asynchronous, while rst = 1):
  - cnt = 0, so sample_clk_en = 0 and bit_clk_en = 0.
  - acc = 0, sample_output = 0, sample_li_offset = 0.
- Release: the first bit_clk_en occurs 7 cycles after the first rising edge with rst = 0; the first sample_clk_en occurs 511 cycles after that edge.
- Periods: sample_clk_en every 512 cycles; bit_clk_en every 8 cycles. Every sample_clk_en coincides with a bit_clk_en.
- Latency: the outputs update on the same edge at which sample_clk_en is high. A consumer sampling at that edge sees the previous sample; the new one is valid for the next 511 cycles.
- Reset mid-operation clears everything immediately, and the divider phase restarts.

## Test plan
- Reset: assert rst mid-run → all outputs 0 asynchronously. Release → sample_clk_en first high 511 cycles after release, then every 512 cycles; bit_clk_en every 8 cycles, 64 per sample period.
- inc = 0x00800000, unmuted:
  - sample_output after successive enables is 0, 402, 804, … (frac alternates 0x00/0x80).
  - Sample 128 = 32767.
  - Period is 512 samples.
  - accumulator_value advances by 0x800000 per enable.
- inc = 0x40000000 → repeating 0, 32767, 0, −32767, and sample_li_offset always 0.
- Wrap: inc = 0xC0000000 → acc 0, 0xC0000000, 0x80000000, 0x40000000, 0, with outputs 0, −32767, 0, 32767.
- Mute: assert nco_mute for 4 enables with inc = 0x40000000 → outputs 0 during mute, accumulator still advancing. Deassert → output resumes at the advanced phase.
- Increment change between enables: only the next enable uses the new step, and there is no glitch on sample_output between enables.
